// File: rtl/usb_in_tx_pkg.sv
// rtl/usb_in_tx_pkg.sv - shared PIDs, handshake bytes, CRC16 constants and FSM states for usb_in_tx
package usb_in_tx_pkg;

   typedef enum logic [3:0] {
      PID_ACK   = 4'h2,
      PID_DATA0 = 4'h3,
      PID_NAK   = 4'hA,
      PID_DATA1 = 4'hB
   } pid_e;

   localparam logic [7:0]  HS_ACK     = 8'hD2;
   localparam logic [7:0]  HS_NAK     = 8'h5A;

   localparam logic [15:0] CRC16_POLY = 16'hA001;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_PID,
      ST_SEND_DATA,
      ST_SEND_CRC_LO,
      ST_SEND_CRC_HI,
      ST_WAIT_ACK
   } state_e;

   // A PID goes on the wire as its 4-bit code with the one's complement in the upper nibble
   function automatic logic [7:0] pid_byte(input logic [3:0] pid);
      return {~pid, pid};
   endfunction

endpackage

// File: rtl/usb_crc16_tx.sv
// rtl/usb_crc16_tx.sv - byte-wide CRC16 accumulator, reflected polynomial, LSB first
module usb_crc16_tx (
   input  logic        clk,
   input  logic        reset,
   input  logic        init,
   input  logic        enable,
   input  logic [7:0]  data,
   output logic [15:0] crc
);
   import usb_in_tx_pkg::*;

   logic [15:0] crc_next;

   // Fold one byte into the running remainder, least-significant bit first
   always_comb begin
      crc_next = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC16_POLY) : (crc_next >> 1);
      end
   end

   // Hold the remainder; init restarts it for a new packet
   always_ff @(posedge clk) begin
      if (reset || init) begin
         crc <= CRC16_INIT;
      end else if (enable) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/usb_in_tx.sv
// rtl/usb_in_tx.sv - IN-transaction DATA packet transmitter; USB_IN_NAK_EN makes empty endpoints answer NAK
module usb_in_tx #(
   parameter int num_endpi   = 1,
   parameter int max_len     = 8,
   parameter int ack_timeout = 288
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_req,
   input  logic [3:0]             in_endp,
   input  logic [num_endpi-1:0]   setup_rcvd,
   input  logic [num_endpi*8-1:0] ep_data,
   input  logic [num_endpi-1:0]   ep_valid,
   input  logic [num_endpi-1:0]   ep_last,
   output logic [num_endpi-1:0]   ep_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic                   busy
);
   import usb_in_tx_pkg::*;

   localparam int CW = $clog2(max_len + 1);
   localparam int TW = $clog2(ack_timeout + 1);
   localparam logic [CW-1:0] LEN_LAST = CW'(max_len - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ack_timeout - 1);
   localparam logic [4:0]    NUM_EP   = 5'(num_endpi);

   state_e                 state;
   logic [3:0]             ep_sel;
   logic                   pid_tgl;
   logic                   nak_mode;
   logic                   data_first;
   logic [CW-1:0]          byte_cnt;
   logic [TW-1:0]          tmo_cnt;
   logic [num_endpi-1:0]   toggle;

   logic [7:0]             cur_data;
   logic                   cur_valid;
   logic                   cur_last;
   logic                   req_tgl;
   logic                   crc_init;
   logic                   crc_en;
   logic [15:0]            crc;

   // Select the byte stream of the endpoint being served
   always_comb begin
      cur_data  = 8'h00;
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      for (int i = 0; i < num_endpi; i++) begin
         if (ep_sel == 4'(i)) begin
            cur_data  = ep_data[i*8 +: 8];
            cur_valid = ep_valid[i];
            cur_last  = ep_last[i];
         end
      end
   end

   // Look up the data toggle of the endpoint named by the incoming token
   always_comb begin
      req_tgl = 1'b0;
      for (int i = 0; i < num_endpi; i++) begin
         if (in_endp == 4'(i)) begin
            req_tgl = toggle[i];
         end
      end
   end

`ifdef USB_IN_NAK_EN
   logic req_valid;

   // An endpoint with nothing queued at token time is answered with NAK
   always_comb begin
      req_valid = 1'b0;
      for (int i = 0; i < num_endpi; i++) begin
         if (in_endp == 4'(i)) begin
            req_valid = ep_valid[i];
         end
      end
   end
`endif

   // Transmit byte for the current state; payload passes straight through from the endpoint
   always_comb begin
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      case (state)
         ST_SEND_PID: begin
            tx_valid = 1'b1;
            tx_data  = nak_mode ? HS_NAK : pid_byte(pid_tgl ? PID_DATA1 : PID_DATA0);
         end
         ST_SEND_DATA: begin
            tx_valid = cur_valid;
            tx_data  = cur_data;
         end
         ST_SEND_CRC_LO: begin
            tx_valid = 1'b1;
            tx_data  = ~crc[7:0];
         end
         ST_SEND_CRC_HI: begin
            tx_valid = 1'b1;
            tx_data  = ~crc[15:8];
         end
         default: begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end
      endcase
   end

   // Consume a payload byte only when the transceiver takes it
   always_comb begin
      ep_ready = '0;
      for (int i = 0; i < num_endpi; i++) begin
         if (state == ST_SEND_DATA && ep_sel == 4'(i)) begin
            ep_ready[i] = ep_valid[i] & tx_ready;
         end
      end
   end

   assign busy     = (state != ST_IDLE);
   assign crc_init = (state == ST_IDLE);
   assign crc_en   = (state == ST_SEND_DATA) && cur_valid && tx_ready;

   usb_crc16_tx u_crc (
      .clk    (clk),
      .reset  (reset),
      .init   (crc_init),
      .enable (crc_en),
      .data   (cur_data),
      .crc    (crc)
   );

   // Packet sequencing, payload length, handshake timeout and per-endpoint data toggles
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ep_sel     <= 4'd0;
         pid_tgl    <= 1'b0;
         nak_mode   <= 1'b0;
         data_first <= 1'b0;
         byte_cnt   <= '0;
         tmo_cnt    <= '0;
         toggle     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_req && ({1'b0, in_endp} < NUM_EP)) begin
                  ep_sel   <= in_endp;
                  pid_tgl  <= req_tgl;
                  byte_cnt <= '0;
`ifdef USB_IN_NAK_EN
                  nak_mode <= ~req_valid;
`else
                  nak_mode <= 1'b0;
`endif
                  state    <= ST_SEND_PID;
               end
            end
            ST_SEND_PID: begin
               if (tx_ready) begin
                  if (nak_mode) begin
                     state <= ST_IDLE;
                  end else begin
                     data_first <= 1'b1;
                     state      <= ST_SEND_DATA;
                  end
               end
            end
            ST_SEND_DATA: begin
               data_first <= 1'b0;
               if (cur_valid && tx_ready) begin
                  byte_cnt <= byte_cnt + 1'b1;
                  if (cur_last || byte_cnt == LEN_LAST) begin
                     state <= ST_SEND_CRC_LO;
                  end
               end else if (data_first && !cur_valid) begin
                  // nothing queued when the payload phase opens: zero-length packet
                  state <= ST_SEND_CRC_LO;
               end
            end
            ST_SEND_CRC_LO: begin
               if (tx_ready) begin
                  state <= ST_SEND_CRC_HI;
               end
            end
            ST_SEND_CRC_HI: begin
               if (tx_ready) begin
                  tmo_cnt <= '0;
                  state   <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (rx_valid) begin
                  if (rx_data == HS_ACK) begin
                     for (int i = 0; i < num_endpi; i++) begin
                        if (ep_sel == 4'(i)) begin
                           toggle[i] <= ~toggle[i];
                        end
                     end
                  end
                  state <= ST_IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         // SETUP forces DATA1 and wins over an ACK toggle in the same cycle
         for (int i = 0; i < num_endpi; i++) begin
            if (setup_rcvd[i]) begin
               toggle[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_in_tx.sv
// tb/tb_usb_in_tx.sv - directed self-checking bench for usb_in_tx (expectations follow USB_IN_NAK_EN)
module tb_usb_in_tx;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic        in_req;
   logic [3:0]  in_endp;
   logic [1:0]  setup_rcvd;
   logic [15:0] ep_data;
   logic [1:0]  ep_valid;
   logic [1:0]  ep_last;
   logic [1:0]  ep_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  cap[$];
   logic [8:0]  src0[$];
   logic [8:0]  src1[$];
   logic [1:0]  rdy_seen = 2'b00;
   int          rdy_cnt0 = 0;

   usb_in_tx #(.num_endpi(2), .max_len(8), .ack_timeout(288)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_req     (in_req),
      .in_endp    (in_endp),
      .setup_rcvd (setup_rcvd),
      .ep_data    (ep_data),
      .ep_valid   (ep_valid),
      .ep_last    (ep_last),
      .ep_ready   (ep_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Record completed transmit handshakes and endpoint consumption mid-cycle
   always @(negedge clk) begin
      rdy_seen = ep_ready;
      if (!reset && tx_valid && tx_ready) cap.push_back(tx_data);
      if (!reset && ep_ready[0]) rdy_cnt0++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_crc(input bq_t b);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (b[k]) begin
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[k][j];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
         end
      end
      return ~c;
   endfunction

   function automatic bq_t make_pkt(input logic [7:0] pid, input bq_t pl);
      bq_t         q;
      logic [15:0] r;
      q.push_back(pid);
      foreach (pl[k]) q.push_back(pl[k]);
      r = ref_crc(pl);
      q.push_back(r[7:0]);
      q.push_back(r[15:8]);
      return q;
   endfunction

   task automatic drive_src();
      ep_valid = 2'b00;
      ep_last  = 2'b00;
      ep_data  = 16'h0000;
      if (src0.size() > 0) begin
         ep_valid[0]   = 1'b1;
         ep_last[0]    = src0[0][8];
         ep_data[7:0]  = src0[0][7:0];
      end
      if (src1.size() > 0) begin
         ep_valid[1]   = 1'b1;
         ep_last[1]    = src1[0][8];
         ep_data[15:8] = src1[0][7:0];
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rdy_seen[0] && src0.size() > 0) src0.delete(0);
      if (rdy_seen[1] && src1.size() > 0) src1.delete(0);
      drive_src();
   endtask

   task automatic load(input int ep, input bq_t pl, input bit last);
      foreach (pl[k]) begin
         logic [8:0] e;
         e = {(last && k == pl.size() - 1), pl[k]};
         if (ep == 0) src0.push_back(e);
         else         src1.push_back(e);
      end
      drive_src();
   endtask

   task automatic send_in(input logic [3:0] ep);
      in_req  = 1'b1;
      in_endp = ep;
      step();
      in_req  = 1'b0;
   endtask

   task automatic wait_bytes(input int n);
      int c;
      c = 0;
      while (cap.size() < n && c < 300) begin
         step();
         c++;
      end
      if (cap.size() < n) check("wait_bytes_timeout", cap.size(), n);
   endtask

   task automatic respond(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      step();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic check_bytes(input string tag, input bq_t exp);
      check({tag, "_len"}, cap.size(), exp.size());
      foreach (exp[k]) begin
         if (k < cap.size()) check($sformatf("%s_b%0d", tag, k), cap[k], exp[k]);
      end
      cap.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      bq_t p;
      bq_t p8;
      bq_t e;

      reset = 1'b1; in_req = 1'b0; in_endp = 4'd0; setup_rcvd = 2'b00;
      ep_data = 16'h0; ep_valid = 2'b00; ep_last = 2'b00;
      tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_ep_ready", ep_ready, 0);
      reset = 1'b0;
      step();

      // token for an endpoint that does not exist
      send_in(4'd2);
      step();
      check("bad_endp_busy", busy, 0);
      check("bad_endp_bytes", cap.size(), 0);

      // three-byte packet, no handshake: timeout boundary, extra token ignored
      p = '{8'h01, 8'h02, 8'h03};
      load(0, p, 1'b1);
      rdy_cnt0 = 0;
      send_in(4'd0);
      wait_bytes(6);
      send_in(4'd0);
      repeat (286) step();
      check("tmo_still_busy", busy, 1);
      step();
      check("tmo_idle", busy, 0);
      check("pkt1_ready_cnt", rdy_cnt0, 3);
      check_bytes("pkt1", make_pkt(8'hC3, p));

      // host retries: same PID and payload, then ACK
      load(0, p, 1'b1);
      send_in(4'd0);
      wait_bytes(6);
      respond(8'hD2);
      check("ack_idle", busy, 0);
      check_bytes("retry", make_pkt(8'hC3, p));

      // ten bytes offered without last: only max_len go out; non-ACK reply
      p.delete();
      p8.delete();
      for (int v = 0; v < 10; v++) p.push_back(8'h10 + v[7:0]);
      for (int v = 0; v < 8; v++) p8.push_back(8'h10 + v[7:0]);
      load(0, p, 1'b0);
      rdy_cnt0 = 0;
      send_in(4'd0);
      wait_bytes(11);
      respond(8'h5A);
      check("other_idle", busy, 0);
      check("maxlen_ready_cnt", rdy_cnt0, 8);
      check("maxlen_left", src0.size(), 2);
      check_bytes("maxlen", make_pkt(8'h4B, p8));
      src0.delete();
      drive_src();
      step();

      // transceiver stalls mid-payload; toggle still DATA1 after the non-ACK reply
      p = '{8'h21, 8'h22, 8'h23, 8'h24};
      load(0, p, 1'b1);
      send_in(4'd0);
      wait_bytes(2);
      tx_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check("stall_valid", tx_valid, 1);
         check("stall_data", tx_data, 8'h22);
      end
      tx_ready = 1'b1;
      wait_bytes(7);
      respond(8'hD2);
      check_bytes("stall", make_pkt(8'h4B, p));

      // SETUP forces DATA1 on endpoint 0 (toggle was DATA0 after the ACK)
      setup_rcvd = 2'b01;
      step();
      setup_rcvd = 2'b00;
      p = '{8'h55};
      load(0, p, 1'b1);
      send_in(4'd0);
      wait_bytes(4);
      respond(8'hD2);
      check_bytes("setup", make_pkt(8'h4B, p));

      // empty endpoint 1
`ifdef USB_IN_NAK_EN
      send_in(4'd1);
      wait_bytes(1);
      check("nak_idle", busy, 0);
      e = '{8'h5A};
      check_bytes("nak", e);
`else
      send_in(4'd1);
      wait_bytes(3);
      respond(8'h5A);
      check("zlp_idle", busy, 0);
      e = '{8'hC3, 8'h00, 8'h00};
      check_bytes("zlp", e);
`endif

      // reset in the middle of a packet clears everything including toggles
      setup_rcvd = 2'b01;
      step();
      setup_rcvd = 2'b00;
      p = '{8'h31, 8'h32, 8'h33};
      load(1, p, 1'b1);
      send_in(4'd1);
      wait_bytes(2);
      reset = 1'b1;
      step();
      check("mid_rst_tx_valid", tx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ep_ready", ep_ready, 0);
      reset = 1'b0;
      src1.delete();
      drive_src();
      cap.delete();
      step();
      p = '{8'h66};
      load(0, p, 1'b1);
      send_in(4'd0);
      wait_bytes(4);
      respond(8'hD2);
      check_bytes("post_rst", make_pkt(8'hC3, p));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
